dmem_arbiter: RTL



---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arb_waitctr.sv | 40 ++++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing constants for the data-memory arbiter.
// Optional statistics are enabled with the DMEM_ARB_PERF_EN macro.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int WAIT_W     = 4;
  localparam int PERF_W     = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    DBG_RD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_waitctr.sv
// Clearable up-counter that stops at a programmable limit. It serves both as
// the debug starvation counter and as a saturating event counter.
module dmem_arb_waitctr
  import dmem_arb_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic         at_limit_o,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_limit_o = (cnt_q == limit_i);
  assign count_o    = cnt_q;

  // Clear wins over increment; increments at the limit are dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the processor load/store port and
// the debug requester. DMEM_ARB_PERF_EN adds stall/grant statistics outputs.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut,
`ifdef DMEM_ARB_PERF_EN
  output logic [PERF_W-1:0] perf_cpu_stalls,
  output logic [PERF_W-1:0] perf_dbg_grants,
`endif
  output arb_state_e        arb_state
);

  logic              contend;
  logic              wait_at_limit;
  logic [WAIT_W-1:0] unused_wait_count;
  logic              unused_cpu_addr_hi;

  arb_state_e        state_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  assign unused_cpu_addr_hi = ^cpu_addr[31:ADDR_W];

  // Handshake: dbg_req holds its command until dbg_gnt is high in the same
  // cycle; the access is committed at that rising edge. The processor has no
  // handshake: cpu_stall tells it the memory stage did not happen this cycle.
  assign contend   = cpu_req & dbg_req;
  assign dbg_gnt   = reset_n & dbg_req & (~cpu_req | wait_at_limit);
  assign cpu_stall = reset_n & contend & wait_at_limit;

  dmem_arb_waitctr #(.W(WAIT_W)) u_wait (
    .clock      (clock),
    .reset_n    (reset_n),
    .inc_i      (contend & ~wait_at_limit),
    .clr_i      (~dbg_req | dbg_gnt),
    .limit_i    (WAIT_W'(MAX_WAIT)),
    .at_limit_o (wait_at_limit),
    .count_o    (unused_wait_count)
  );

  // With no owner the CPU address/data still reach the RAM, write disabled.
  always_comb begin
    ram_wEn    = 1'b0;
    ram_addr   = cpu_addr[ADDR_W-1:0];
    ram_dataIn = cpu_data;
    if (dbg_gnt) begin
      ram_wEn    = dbg_we;
      ram_addr   = dbg_addr;
      ram_dataIn = dbg_wdata;
    end else if (cpu_req) begin
      ram_wEn = reset_n & cpu_wren;
    end
  end

  // DBG_RD marks the cycle in which the RAM presents a debug read result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= (state_q == DBG_RD);
      if (state_q == DBG_RD) begin
        rdata_q <= ram_dataOut;
      end
      state_q <= (dbg_gnt && !dbg_we) ? DBG_RD : IDLE;
    end
  end

  assign cpu_q      = ram_dataOut;
  assign dbg_rvalid = rvalid_q;
  assign dbg_rdata  = rdata_q;
  assign arb_state  = state_q;

`ifdef DMEM_ARB_PERF_EN
  logic unused_stall_sat;
  logic unused_grant_sat;

  dmem_arb_waitctr #(.W(PERF_W)) u_perf_stall (
    .clock      (clock),
    .reset_n    (reset_n),
    .inc_i      (cpu_stall),
    .clr_i      (1'b0),
    .limit_i    ({PERF_W{1'b1}}),
    .at_limit_o (unused_stall_sat),
    .count_o    (perf_cpu_stalls)
  );

  dmem_arb_waitctr #(.W(PERF_W)) u_perf_grant (
    .clock      (clock),
    .reset_n    (reset_n),
    .inc_i      (dbg_gnt),
    .clr_i      (1'b0),
    .limit_i    ({PERF_W{1'b1}}),
    .at_limit_o (unused_grant_sat),
    .count_o    (perf_dbg_grants)
  );
`endif

endmodule
